// File: rtl/pkt_pkg.sv
// Shared definitions for the packet transmit/receive paths.
package pkt_pkg;

  localparam int unsigned PKT_W_DEF = 64;
  localparam logic        IDLE_LVL  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } pkt_state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pkt_tx_baud.sv
// Bit-rate clock-enable generator: one tick every DIV enabled clocks.
module pkt_tx_baud
  import pkt_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_bit_tick_c
);

  localparam int unsigned DIV_W = cnt_w(DIV);

  logic [DIV_W-1:0] r_div_cnt;

  assign o_bit_tick_c = i_en && (r_div_cnt == DIV_W'(DIV - 1));

  // Divider counter: counts 0..DIV-1 while enabled, cleared on request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
    end else if (i_clr || o_bit_tick_c) begin
      r_div_cnt <= '0;
    end else if (i_en) begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/pkt_tx.sv
// Serial packet transmitter: MSB-first, DIV clocks per bit, idle gap after each frame.
module pkt_tx
  import pkt_pkg::*;
#(
  parameter int unsigned PKT_W    = PKT_W_DEF,
  parameter int unsigned DIV      = 4,
  parameter int unsigned GAP_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PKT_W-1:0] pkt_data,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  logic             abort,
  output logic             dout,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int unsigned BIT_W    = cnt_w(PKT_W);
  localparam int unsigned GAP_CLKS = GAP_BITS * DIV;
  localparam int unsigned GAP_W    = cnt_w(GAP_CLKS + 1);
  localparam int unsigned GAP_LAST = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;

  pkt_state_e       r_state;
  logic [PKT_W-1:0] r_shift;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_tail;
  logic             r_dout;
  logic             r_busy;
  logic             r_done;

  logic w_accept;
  logic w_baud_en;
  logic w_bit_tick;

  // dout lags the shift register by one clock; r_tail covers that final clock.
  assign w_baud_en = (r_state == ST_SHIFT) && !r_tail;
  assign w_accept  = pkt_valid && pkt_ready;
  assign pkt_ready = rst && (r_state == ST_IDLE) && !abort;
  assign dout      = r_dout;
  assign tx_busy   = r_busy;
  assign tx_done   = r_done;

  pkt_tx_baud #(
    .DIV (DIV)
  ) u_baud (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (!w_baud_en || abort),
    .i_en         (w_baud_en),
    .o_bit_tick_c (w_bit_tick)
  );

  // Frame FSM with registered serial output and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_tail    <= 1'b0;
      r_dout    <= IDLE_LVL;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_dout <= IDLE_LVL;
          r_busy <= 1'b0;
          if (w_accept) begin
            r_shift   <= pkt_data;
            r_bit_cnt <= '0;
            r_tail    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            r_dout    <= IDLE_LVL;
            r_busy    <= 1'b0;
            r_bit_cnt <= '0;
            r_tail    <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (r_tail) begin
            r_dout    <= IDLE_LVL;
            r_done    <= 1'b1;
            r_tail    <= 1'b0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_busy    <= (GAP_BITS > 0);
            r_state   <= (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
          end else begin
            r_dout <= r_shift[PKT_W-1];
            if (w_bit_tick) begin
              r_shift <= {r_shift[PKT_W-2:0], 1'b0};
              if (r_bit_cnt == BIT_W'(PKT_W - 1)) begin
                r_tail <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
              end
            end
          end
        end
        ST_GAP: begin
          r_dout <= IDLE_LVL;
          if (abort || (r_gap_cnt == GAP_W'(GAP_LAST))) begin
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          r_dout  <= IDLE_LVL;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_tx.sv
// Directed bench for pkt_tx: one instance at DIV=4/GAP=2, one at DIV=1/GAP=0.
module tb_pkt_tx;

  logic        clk;
  logic        rst;
  logic [63:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        abort;
  logic        dout;
  logic        tx_busy;
  logic        tx_done;

  logic [63:0] pkt_data2;
  logic        pkt_valid2;
  logic        pkt_ready2;
  logic        abort2;
  logic        dout2;
  logic        tx_busy2;
  logic        tx_done2;

  int n_cmp;
  int n_err;

  pkt_tx #(.PKT_W(64), .DIV(4), .GAP_BITS(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .abort     (abort),
    .dout      (dout),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  pkt_tx #(.PKT_W(64), .DIV(1), .GAP_BITS(0)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .pkt_data  (pkt_data2),
    .pkt_valid (pkt_valid2),
    .pkt_ready (pkt_ready2),
    .abort     (abort2),
    .dout      (dout2),
    .tx_busy   (tx_busy2),
    .tx_done   (tx_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one frame on the DIV=4/GAP=2 instance and check every clock of it.
  task automatic send_and_check(input string tag, input logic [63:0] d);
    logic [63:0] cap;
    int          dones;
    logic        e_dout, e_done, e_busy, e_rdy;
    cap   = '0;
    dones = 0;
    pkt_data  = d;
    pkt_valid = 1'b1;
    step();
    pkt_valid = 1'b0;
    pkt_data  = ~d;
    chk({tag, "_acc"}, 0, 64'({dout, tx_done, tx_busy, pkt_ready}), 64'(4'b0010));
    for (int m = 1; m <= 268; m++) begin
      step();
      e_dout = (m >= 1 && m <= 256) ? d[63 - ((m - 1) / 4)] : 1'b0;
      e_done = (m == 257);
      e_busy = (m < 265);
      e_rdy  = !e_busy;
      chk(tag, m, 64'({dout, tx_done, tx_busy, pkt_ready}),
          64'({e_dout, e_done, e_busy, e_rdy}));
      if ((m % 4) == 2 && m <= 256) cap[63 - ((m - 2) / 4)] = dout;
      if (tx_done) dones++;
    end
    chk({tag, "_word"}, 0, cap, d);
    chk({tag, "_ndone"}, 0, 64'(dones), 64'd1);
  endtask

  initial begin
    int          dones;
    logic        e_dout, e_done, e_busy;
    logic [63:0] d1, d2;
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b0;
    pkt_data   = 64'hDEAD_BEEF_0000_0001;
    pkt_valid  = 1'b1;
    abort      = 1'b0;
    pkt_data2  = '0;
    pkt_valid2 = 1'b0;
    abort2     = 1'b0;

    // Reset held with a pending packet
    step();
    step();
    step();
    chk("rst_out", 0, 64'({dout, tx_busy, tx_done, pkt_ready}), 64'(4'b0000));
    chk("rst_rdy2", 0, 64'(pkt_ready2), 64'd0);
    pkt_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("rel_rdy", 0, 64'({pkt_ready, tx_busy, dout}), 64'(3'b100));
    chk("rel_rdy2", 0, 64'(pkt_ready2), 64'd1);

    // Single frame with gap
    send_and_check("frame1", 64'hA5A5_0000_FFFF_1234);

    // Back-to-back on DIV=1, GAP=0 instance
    d1 = 64'h0000_0000_0000_0001;
    d2 = 64'h8000_0000_0000_0000;
    dones = 0;
    pkt_data2  = d1;
    pkt_valid2 = 1'b1;
    step();
    chk("b2b_acc", 0, 64'({dout2, tx_busy2, pkt_ready2}), 64'(3'b010));
    pkt_data2 = d2;
    for (int m = 1; m <= 136; m++) begin
      step();
      if (m >= 1 && m <= 64)        e_dout = d1[63 - (m - 1)];
      else if (m >= 67 && m <= 130) e_dout = d2[63 - (m - 67)];
      else                          e_dout = 1'b0;
      e_done = (m == 65) || (m == 131);
      e_busy = (m <= 64) || (m >= 66 && m <= 130);
      chk("b2b", m, 64'({dout2, tx_done2, tx_busy2, pkt_ready2}),
          64'({e_dout, e_done, e_busy, !e_busy}));
      if (tx_done2) dones++;
      if (m == 66) pkt_valid2 = 1'b0;
    end
    chk("b2b_ndone", 0, 64'(dones), 64'd2);

    // Abort during bit 10
    pkt_data  = 64'hF0F0_1234_5678_9ABC;
    pkt_valid = 1'b1;
    step();
    pkt_valid = 1'b0;
    for (int m = 1; m <= 42; m++) step();
    chk("abt_bit10", 0, 64'(dout), 64'd1);
    abort = 1'b1;
    step();
    chk("abt_out", 0, 64'({dout, tx_done, tx_busy, pkt_ready}), 64'(4'b0000));
    abort = 1'b0;
    #1;
    chk("abt_rdy", 0, 64'(pkt_ready), 64'd1);
    dones = 0;
    for (int m = 0; m < 270; m++) begin
      step();
      if (tx_done || tx_busy) dones++;
    end
    chk("abt_quiet", 0, 64'(dones), 64'd0);
    send_and_check("post_abt", 64'h8123_4567_89AB_CDEF);

    // Asynchronous reset between edges mid-frame
    pkt_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    pkt_valid = 1'b1;
    step();
    pkt_valid = 1'b0;
    for (int m = 1; m <= 20; m++) step();
    chk("ar_pre", 0, 64'({dout, tx_busy}), 64'(2'b11));
    #2;
    rst = 1'b0;
    #1;
    chk("ar_out", 0, 64'({dout, tx_done, tx_busy, pkt_ready}), 64'(4'b0000));
    step();
    step();
    chk("ar_hold", 0, 64'({dout, tx_done, tx_busy}), 64'(3'b000));
    rst = 1'b1;
    step();
    send_and_check("post_rst", 64'h0123_4567_89AB_CDEF);

    // abort and pkt_valid together in IDLE
    pkt_data  = 64'h5555_AAAA_3C3C_C3C3;
    pkt_valid = 1'b1;
    abort     = 1'b1;
    #1;
    chk("ia_rdy", 0, 64'(pkt_ready), 64'd0);
    step();
    chk("ia_busy", 0, 64'({tx_busy, dout}), 64'(2'b00));
    abort = 1'b0;
    step();
    pkt_valid = 1'b0;
    chk("ia_acc", 0, 64'(tx_busy), 64'd1);
    dones = 0;
    for (int m = 1; m <= 268; m++) begin
      step();
      if (tx_done) dones++;
      if (m == 2) chk("ia_msb", 0, 64'(dout), 64'd0);
      if (m == 6) chk("ia_b1", 0, 64'(dout), 64'd1);
    end
    chk("ia_ndone", 0, 64'(dones), 64'd1);
    chk("ia_end", 0, 64'({tx_busy, pkt_ready}), 64'(2'b01));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_tx.md
Name: pkt_tx

Overview:
Serial packet transmitter: the transmit-side counterpart of the RF receive path (shift buffer, packet register, SPI byte buffer).
- Accepts a PKT_W-bit packet word over a valid/ready handshake.
- Serializes it MSB-first onto dout, holding each bit for DIV clocks.
- Enforces an inter-packet gap of GAP_BITS bit periods.
- Sits between the SPI-side packet source and the RF modulator input.

Parameters:
PKT_W, 64, packet width in bits (≥8)
DIV, 4, clocks per transmitted bit (≥1)
GAP_BITS, 2, idle bit periods after each packet (≥0)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
pkt_data  in  PKT_W  packet to send, sampled on accept
pkt_valid  in  1  source has a packet
pkt_ready  out  1  transmitter can accept
abort  in  1  synchronous cancel of current frame
dout  out  1  serial data to RF modulator
tx_busy  out  1  high in SHIFT and GAP
tx_done  out  1  one-cycle pulse at normal end of the data bits

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE; shift register, div counter and bit counter cleared.
- dout=0, tx_busy=0, tx_done=0, pkt_ready=0 while rst low.
- Reset mid-frame drops the frame with no tx_done.

Handshake and ready:
- pkt_ready = (state==IDLE) && !abort; registered state, combinational output.
- Accept = pkt_valid && pkt_ready at a rising edge, i.e. edge k. pkt_data may change freely after edge k.

States:
- IDLE:
  - dout=0.
  - On accept: load shift register, div_cnt=0, bit_cnt=0, go to SHIFT.
- SHIFT:
  - dout = shift_reg[PKT_W-1], registered, so the first bit appears after edge k.
  - div_cnt counts 0..DIV-1. On wrap: shift left by 1, bit_cnt++.
  - Bit j (j=0 is the MSB) is driven from edge k+1+DIV·j until edge k+1+DIV·(j+1).
  - When bit_cnt reaches PKT_W-1 and div_cnt wraps (edge k+PKT_W·DIV+1):
    - tx_done=1 for exactly that one cycle.
    - If GAP_BITS>0, go to GAP; else go to IDLE.
- GAP:
  - dout=0 for GAP_BITS·DIV clocks, then go to IDLE.
  - pkt_ready is first high after edge k+(PKT_W+GAP_BITS)·DIV+1.
- abort=1 in SHIFT or GAP:
  - Next edge goes to IDLE, dout=0, no tx_done, counters cleared.
  - abort in IDLE blocks acceptance that cycle.
- Back-to-back: with GAP_BITS=0 and pkt_valid held, the next accept occurs the cycle after the return to IDLE. That gives one idle clock between frames, which is acceptable.

Counter widths:
- div_cnt: $clog2(DIV) bits, minimum 1; DIV=1 means a wrap every clock.
- bit_cnt: $clog2(PKT_W) bits.
- gap counter: $clog2(GAP_BITS·DIV+1) bits.
- No counter may wrap past its terminal value.

Other rules:
- pkt_valid with no ready is ignored; the source must hold it.
- The module never drops an accepted packet except on abort or reset.

Decomposition:
Shared package pkt_pkg:
- state enum {IDLE, SHIFT, GAP}
- default PKT_W
- IDLE_LVL=1'b0
The receive path uses the same PKT_W.

Sub-module pkt_tx_baud:
- DIV clock-enable generator with a clear input.
- Emits a bit_tick on div_cnt wrap.
- Reusable later for a receive-side bit-rate counter.

Test Plan:
1. Reset: hold rst=0 with pkt_valid=1 → dout=0, pkt_ready=0, tx_busy=0. Release → pkt_ready=1 next cycle.
2. Single frame, DIV=4, GAP_BITS=2, pkt_data=64'hA5A5_0000_FFFF_1234, accept at edge k → dout=1,0,1,0,0,1,0,1… each held 4 clocks. Last bit (0) spans edges k+253..k+257. tx_done single pulse after edge k+257. pkt_ready high after edge k+265. Captured 64 bits equal input.
3. Back-to-back with pkt_valid held high, GAP_BITS=0, DIV=1, data 64'h1 then 64'h8000_0000_0000_0000 → two frames, one idle clock between them, exactly two tx_done pulses.
4. Abort at bit 10 of a frame → dout=0 and state IDLE next edge, no tx_done. A following packet transmits correctly from its MSB.
5. Asynchronous reset asserted mid-SHIFT between clock edges → outputs clear immediately, no tx_done. After release, a fresh frame transmits normally.
6. abort and pkt_valid both high in IDLE → no accept, tx_busy stays 0. With abort low next cycle → accept proceeds.
